// File: rtl/planificador_rr_pkg.sv
// Shared definitions for the round-robin FIFO scheduler: state encoding,
// default widths and the port count.
package planificador_rr_pkg;

    localparam int NUM_PORTS   = 4;
    localparam int DATA_W_DEF  = 10;
    localparam int DEST_LO_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ROUTE = 2'd2
    } state_t;

    function automatic logic [NUM_PORTS-1:0] onehot(input logic [1:0] idx);
        return NUM_PORTS'(1) << idx;
    endfunction

endpackage

// File: rtl/planificador_rr_rr_grant.sv
// Combinational 4-way round-robin picker: first requester at or after ptr,
// wrapping modulo 4.
module rr_grant
    import planificador_rr_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [1:0]           gnt_idx,
    output logic                 gnt_valid
);

    logic [1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_idx   = ptr;
        gnt_valid = 1'b0;
        idx       = ptr;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                gnt_idx   = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/planificador_rr.sv
// Round-robin scheduler moving words from four input FIFOs to four output
// FIFOs, with head-of-line hold on a full destination and per-output counters.
module planificador_rr
    import planificador_rr_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEST_LO = DEST_LO_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORTS-1:0]         in_empty,
    input  logic [NUM_PORTS-1:0]         out_full,
    input  logic [DATA_W-1:0]            dato0_i,
    input  logic [DATA_W-1:0]            dato1_i,
    input  logic [DATA_W-1:0]            dato2_i,
    input  logic [DATA_W-1:0]            dato3_i,
    output logic [NUM_PORTS-1:0]         pop,
    output logic [NUM_PORTS-1:0]         push,
    output logic [DATA_W-1:0]            dato_o,
    output logic [NUM_PORTS*CNT_W-1:0]   cnt_o,
    output logic                         busy
);

    state_t                            state_q, state_d;
    logic [1:0]                        rr_q, gnt_q, gnt_idx, dest;
    logic                              gnt_valid, route_ok;
    logic [DATA_W-1:0]                 held_q, last_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  dato_in;
    logic [NUM_PORTS-1:0][CNT_W-1:0]   cnt_q;
    logic [NUM_PORTS-1:0]              pop_c, push_c;

    assign dato_in  = {dato3_i, dato2_i, dato1_i, dato0_i};
    assign dest     = held_q[DEST_LO+1:DEST_LO];
    assign route_ok = (state_q == ROUTE) && !out_full[dest];

    rr_grant u_rr_grant (
        .req       (~in_empty),
        .ptr       (rr_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d = state_q;
        pop_c   = '0;
        push_c  = '0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    pop_c   = onehot(gnt_idx);
                    state_d = FETCH;
                end
            end
            FETCH: state_d = ROUTE;
            ROUTE: begin
                if (route_ok) begin
                    push_c  = onehot(dest);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are masked during reset so an aborted hold never leaks a push.
    assign pop  = reset ? '0 : pop_c;
    assign push = reset ? '0 : push_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            held_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && gnt_valid)
                gnt_q <= gnt_idx;
            if (state_q == FETCH)
                held_q <= dato_in[gnt_q];
            if (route_ok) begin
                last_q       <= held_q;
                cnt_q[dest]  <= cnt_q[dest] + CNT_W'(1);
                rr_q         <= gnt_q + 2'd1;
            end
        end
    end

    // While routing the held word is presented; otherwise the last pushed word.
    assign dato_o = (state_q == ROUTE) ? held_q : last_q;
    assign cnt_o  = cnt_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_planificador_rr.sv
// Scoreboard bench: a queue-based round-robin model predicts pop order and
// pushed words; a negedge monitor checks whatever the DUT presents.
module tb_planificador_rr;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  in_empty = 4'hF;
    logic [3:0]  out_full = 4'h0;
    logic [9:0]  dato_v [4];
    logic [3:0]  pop, push;
    logic [9:0]  dato_o;
    logic [31:0] cnt_o;
    logic        busy;

    always #5 clk = ~clk;

    planificador_rr dut (
        .clk      (clk),
        .reset    (reset),
        .in_empty (in_empty),
        .out_full (out_full),
        .dato0_i  (dato_v[0]),
        .dato1_i  (dato_v[1]),
        .dato2_i  (dato_v[2]),
        .dato3_i  (dato_v[3]),
        .pop      (pop),
        .push     (push),
        .dato_o   (dato_o),
        .cnt_o    (cnt_o),
        .busy     (busy)
    );

    typedef struct {
        logic [3:0] push;
        logic [9:0] data;
    } exp_t;

    exp_t       exp_push_q[$];
    int         exp_pop_q[$];
    logic [9:0] fq[4][$];
    logic [9:0] mq[4][$];
    int         ptr_m = 0;
    int         cnt_m[4] = '{0, 0, 0, 0};
    logic [3:0] out_full_cmd = 4'h0;
    bit         bp_rand = 1'b0;
    bit         chk_gap = 1'b0;
    int         phase = 0;
    int         vecs = 0;
    int         errs = 0;
    int         cyc = 0;

    function automatic logic [3:0] oh(input int i);
        return 4'(1 << i);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Input FIFO emulation: a pop seen during a cycle presents the head word
    // after the following edge, and the empty flags follow the queues.
    initial begin
        logic [3:0] pend;
        for (int i = 0; i < 4; i++) dato_v[i] = '0;
        forever begin
            @(negedge clk);
            pend = pop;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && fq[i].size() > 0) dato_v[i] = fq[i].pop_front();
                in_empty[i] = (fq[i].size() == 0);
            end
            out_full = bp_rand ? (4'($urandom) & 4'($urandom)) : out_full_cmd;
        end
    end

    // Monitor
    int last_pop_cyc = 0;
    int pop_phase = -1;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            if (pop != 0 || push != 0)
                chk("pop_push_excl", 64'(pop != 0 && push != 0), 64'd0);
            if (pop != 0) begin
                if (exp_pop_q.size() == 0) chk("unexpected_pop", 64'(pop), 64'd0);
                else chk("pop_grant", 64'(pop), 64'(oh(exp_pop_q.pop_front())));
                if (chk_gap && pop_phase == phase)
                    chk("pop_gap", 64'(cyc - last_pop_cyc), 64'd3);
                last_pop_cyc = cyc;
                pop_phase    = phase;
            end
            if (push != 0) begin
                chk("push_vs_full", 64'(push & out_full), 64'd0);
                if (exp_push_q.size() == 0) chk("unexpected_push", 64'(push), 64'd0);
                else begin
                    e = exp_push_q.pop_front();
                    chk("push_port", 64'(push), 64'(e.push));
                    chk("push_data", 64'(dato_o), 64'(e.data));
                end
                if (chk_gap && pop_phase == phase)
                    chk("pop_to_push", 64'(cyc - last_pop_cyc), 64'd2);
            end
        end
    end

    // Reference model: hand the staged words to the FIFOs, then serve them
    // in round-robin order from the current pointer.
    task automatic commit();
        int idx;
        int d;
        logic [9:0] w;
        exp_t e;
        for (int i = 0; i < 4; i++)
            foreach (mq[i][k]) fq[i].push_back(mq[i][k]);
        forever begin
            idx = -1;
            for (int k = 0; k < 4; k++)
                if (idx < 0 && mq[(ptr_m + k) % 4].size() > 0) idx = (ptr_m + k) % 4;
            if (idx < 0) break;
            w = mq[idx].pop_front();
            d = int'(w[9:8]);
            exp_pop_q.push_back(idx);
            e.push = oh(d);
            e.data = w;
            exp_push_q.push_back(e);
            cnt_m[d] = (cnt_m[d] + 1) % 256;
            ptr_m    = (idx + 1) % 4;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_push_q.size() > 0 || exp_pop_q.size() > 0 || busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            vecs++;
            errs++;
            $display("FAIL drain_timeout: %0d pushes pending, expected 0", exp_push_q.size());
        end
    endtask

    task automatic wait_pop();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pop == 0 && n < 50);
        chk("pop_seen", 64'(pop != 0), 64'd1);
    endtask

    task automatic chk_counts(input string nm);
        for (int j = 0; j < 4; j++) chk(nm, 64'(cnt_o[8*j +: 8]), 64'(cnt_m[j]));
    endtask

    initial begin
        // Reset hold with every input loaded, then fairness over 12 dest-0 words
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 3; k++) mq[i].push_back({2'b00, 8'($urandom)});
        phase = 1; chk_gap = 1'b1;
        commit();
        repeat (3) begin
            @(negedge clk);
            chk("rst_pop", 64'(pop), 64'd0);
            chk("rst_push", 64'(push), 64'd0);
            chk("rst_cnt", 64'(cnt_o), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_dato", 64'(dato_o), 64'd0);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("first_pop", 64'(pop), 64'h1);
        drain();
        chk("fair_cnt0", 64'(cnt_o[7:0]), 64'd12);
        chk_counts("cnt_fair");

        // Single word from FIFO2 to output 1
        phase = 2;
        mq[2].push_back(10'h1A5);
        commit();
        drain();
        chk("single_cnt1", 64'(cnt_o[15:8]), 64'd1);
        chk("single_dato_hold", 64'(dato_o), 64'h1A5);

        // Scan resumes at index 3
        phase = 3;
        mq[0].push_back(10'h0AA);
        mq[3].push_back(10'h155);
        commit();
        drain();
        chk_counts("cnt_scan");

        // Back-pressure on output 3 for 5 cycles
        phase = 4; chk_gap = 1'b0;
        out_full_cmd = 4'b1000;
        repeat (2) @(negedge clk);
        mq[0].push_back(10'h300);
        commit();
        wait_pop();
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_busy", 64'(busy), 64'd1);
            chk("hold_push", 64'(push), 64'd0);
            chk("hold_pop", 64'(pop), 64'd0);
            chk("hold_dato", 64'(dato_o), 64'h300);
        end
        out_full_cmd = 4'b0000;
        @(negedge clk);
        chk("release_push", 64'(push), 64'h8);
        chk("release_dato", 64'(dato_o), 64'h300);
        drain();
        chk_counts("cnt_bp");

        // Reset pulse while holding a word for output 3 (word is dropped)
        phase = 5;
        out_full_cmd = 4'b1000;
        repeat (2) @(negedge clk);
        fq[2].push_back(10'h3C1);
        exp_pop_q.push_back(2);
        wait_pop();
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        out_full_cmd = 4'b0000;
        ptr_m = 0;
        for (int j = 0; j < 4; j++) cnt_m[j] = 0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cnt", 64'(cnt_o), 64'd0);
        repeat (4) @(negedge clk);
        chk("midrst_cnt3", 64'(cnt_o[31:24]), 64'd0);
        mq[0].push_back(10'h011);
        mq[1].push_back(10'h022);
        commit();
        drain();
        chk_counts("cnt_after_rst");

        // Counter wrap on output 2 under random back-pressure
        phase = 6; bp_rand = 1'b1;
        for (int n = 0; n < 255; n++) mq[$urandom_range(0, 3)].push_back({2'b10, 8'($urandom)});
        commit();
        drain();
        chk("wrap_255", 64'(cnt_o[23:16]), 64'hFF);
        mq[$urandom_range(0, 3)].push_back({2'b10, 8'($urandom)});
        commit();
        drain();
        chk("wrap_256", 64'(cnt_o[23:16]), 64'h00);

        // Random traffic
        phase = 7;
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 24; n++) mq[$urandom_range(0, 3)].push_back(10'($urandom));
            commit();
            drain();
            chk_counts("cnt_rand");
        end
        bp_rand = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/planificador_rr.md
Name: planificador_rr

Overview:
- Round-robin scheduler that moves 10-bit words from the four input FIFOs (FIFO0–FIFO3) to the four output FIFOs (FIFO4–FIFO7).
- Sits between the xfifo instances in the integracion switch. It replaces the fixed-priority pop/push sequencing with fair arbitration, head-of-line holding and per-output word counters.
- The destination is taken from the top two bits of each word.

Parameters:
- DATA_W, 10, word width.
- DEST_LO, 8, LSB of the 2-bit destination field; the field is bits [DEST_LO+1:DEST_LO].
- CNT_W, 8, width of each per-output word counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_empty  input  4  empty flags of FIFO0..FIFO3; bit i = FIFO i.
- out_full  input  4  full (almost-full, high threshold) flags of FIFO4..FIFO7; bit j = FIFO 4+j.
- dato0_i, dato1_i, dato2_i, dato3_i  input  DATA_W each  read data of FIFO0..FIFO3.
- pop  output  4  one-hot pop strobe to FIFO0..FIFO3.
- push  output  4  one-hot push strobe to FIFO4..FIFO7.
- dato_o  output  DATA_W  write data, shared by all output FIFOs.
- cnt_o  output  4*CNT_W  word counters; slice j = words pushed to FIFO 4+j.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: pop=0, push=0, dato_o=0, cnt_o=0, busy=0. Internal state: rr pointer=0, holding register=0, state=IDLE.
- Reset asserted mid-operation (any state) aborts at the next edge. A held word is discarded and its count is not incremented.
- Input FIFO read timing: data is valid on dato*_i the cycle after pop is asserted.
- FSM states:
  - IDLE:
    - If in_empty==4'b1111, stay in IDLE.
    - Otherwise, grant the first non-empty index scanning from rr upward, modulo 4.
    - Assert pop[grant] for exactly one cycle and go to FETCH.
  - FETCH:
    - Capture dato{grant}_i into the holding register.
    - Decode dest = held[DEST_LO+1:DEST_LO].
    - Go to ROUTE.
  - ROUTE:
    - If out_full[dest]==0: assert push[dest] for one cycle with dato_o=held word. Increment cnt slice dest, wrapping at 2^CNT_W. Set rr=(grant+1) mod 4. Go to IDLE.
    - If out_full[dest]==1: stay in ROUTE (head-of-line hold). dato_o keeps the held word, push stays 0, and no further pops are issued.
- Latency and throughput:
  - Minimum 3 cycles per word: pop → capture → push.
  - Sustained throughput is one word per 3 cycles with no back-pressure.
- pop and push are never asserted in the same cycle. At most one bit of each is set at a time.
- dato_o holds its last pushed value between pushes; it is not zeroed.
- An empty flag that changes while in FETCH or ROUTE has no effect until the next IDLE.
- out_full deasserting while in ROUTE causes the push on that same cycle (combinational on the registered state).
- Fairness: with all four inputs continuously non-empty, grants cycle 0,1,2,3,0,…
- Counter wrap: 255+1 → 0 with CNT_W=8. There is no saturation and no error flag.

Decomposition:
- Shared package (or include file): state encodings IDLE=2'd0, FETCH=2'd1, ROUTE=2'd2; DEST_LO/DATA_W defaults; NUM_PORTS=4.
- One natural sub-module, rr_grant: combinational 4-way round-robin picker.
  - Inputs: req[3:0] (~in_empty) and ptr[1:0].
  - Outputs: gnt_idx[1:0] and gnt_valid.
- The FSM, holding register and counters stay in planificador_rr.

Test Plan:
- Reset hold: reset=1 for 3 cycles with in_empty=4'b0000 → pop=0, push=0, cnt_o=0, busy=0 throughout. The first pop occurs 1 cycle after reset drops, on pop[0].
- Single word: FIFO2 holds 10'h1A5 (dest=2'b01), all others empty, out_full=0 → pop=4'b0100 at t, push=4'b0010 at t+2 with dato_o=10'h1A5. cnt slice 1 = 1. Next scan starts at index 3.
- Fairness: all inputs non-empty for 12 words, every word dest=0 → pop sequence 0,1,2,3,0,1,2,3,0,1,2,3, one pop every 3 cycles. cnt slice 0 = 12.
- Back-pressure: word 10'h300 (dest=3) with out_full[3]=1 for 5 cycles → busy=1, push=0, pop=0 during the hold. push=4'b1000 on the cycle out_full[3] falls, with dato_o=10'h300.
- Reset mid-hold: same stall as the back-pressure case, then reset pulsed for 1 cycle while in ROUTE → push never asserts, cnt slice 3 unchanged (0), rr=0. After reset, the next grant goes to the lowest non-empty index.
- Counter wrap: 256 words to dest=2 → cnt slice 2 reads 8'hFF after the 255th word and 8'h00 after the 256th.
